uart_io_conditioner: RTL and testbench

- Parametrised next-generation pad-side interface for the UART SoC top. It sits between the board pins and the UART core.
- Board-to-core path: synchronises and debounces an SW_W-wide switch bank, synchronises and glitch-filters RX, and generates a core reset with asynchronous assert and synchronous release.
- Core-to-board path: registers TX and the LED_W-wide LED bank, and forces both to safe values while the core is held in reset.

---
 rtl/uart_io_conditioner_if.sv | 28 ++
 rtl/uart_io_conditioner.sv | 202 ++++++++++++++++++++
 tb/tb_uart_io_conditioner.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_io_conditioner_if.sv
// Pin-side and core-side signal bundle for the UART pad conditioner.
// The conditioner attaches as slave; the SoC top (or a bench) drives it as master.
interface uart_io_conditioner_if #(
  parameter int SW_W  = 8,
  parameter int LED_W = 16
);
  logic [SW_W-1:0]  sw_in;
  logic             rx_in;
  logic             tx_in;
  logic [LED_W-1:0] led_in;
  logic             rst_core;
  logic             io_ready;
  logic [SW_W-1:0]  sw_out;
  logic [SW_W-1:0]  sw_chg;
  logic             rx_out;
  logic             tx_out;
  logic [LED_W-1:0] led_out;

  modport master (
    output sw_in, rx_in, tx_in, led_in,
    input  rst_core, io_ready, sw_out, sw_chg, rx_out, tx_out, led_out
  );

  modport slave (
    input  sw_in, rx_in, tx_in, led_in,
    output rst_core, io_ready, sw_out, sw_chg, rx_out, tx_out, led_out
  );
endinterface

// File: rtl/uart_io_conditioner.sv
// Pad-side conditioner between board pins and the UART core: switch debounce,
// RX glitch filter, core reset sequencing and safe-while-reset TX/LED drive.
//
// state   | meaning
// RS_SYNC | waiting for the released reset to emerge from the synchroniser
// RS_HOLD | synchronised release seen, counting RST_HOLD cycles
// RS_RUN  | core out of reset, io_ready asserted
module uart_io_conditioner #(
  parameter int SW_W         = 8,
  parameter int LED_W        = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int RX_FILT      = 3,
  parameter int RST_HOLD     = 16,
  parameter int TX_REG       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_io_conditioner_if.slave  io
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam int DB_W   = $clog2(DEBOUNCE_CYC) + 1;
  localparam int RF_W   = $clog2(RX_FILT) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [RF_W-1:0]   RF_LAST   = RF_W'(RX_FILT - 1);

  typedef enum logic [1:0] {
    RS_SYNC = 2'd0,
    RS_HOLD = 2'd1,
    RS_RUN  = 2'd2
  } rs_state_t;

  rs_state_t          rs_state, rs_state_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_nxt;
  logic [SYNC_STAGES-1:0] rst_sync;
  logic               rst_rel;
  logic               rst_core_q;
  logic               io_ready_q;

  // Reset release synchroniser: async clear, shifts in ones after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_rel = rst_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs_state   <= RS_SYNC;
      hold_cnt   <= '0;
      rst_core_q <= 1'b1;
      io_ready_q <= 1'b0;
    end else begin
      rs_state   <= rs_state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      rst_core_q <= (rs_state_nxt != RS_RUN);
      io_ready_q <= (rs_state_nxt == RS_RUN);
    end
  end

  // The first hold cycle is the edge that observes the synchronised release.
  always_comb begin
    rs_state_nxt = rs_state;
    hold_cnt_nxt = hold_cnt;
    case (rs_state)
      RS_SYNC: begin
        if (rst_rel) begin
          hold_cnt_nxt = HOLD_W'(1);
          rs_state_nxt = (RST_HOLD == 1) ? RS_RUN : RS_HOLD;
        end
      end
      RS_HOLD: begin
        hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        if (hold_cnt == HOLD_LAST) begin
          rs_state_nxt = RS_RUN;
        end
      end
      RS_RUN: begin
        rs_state_nxt = RS_RUN;
      end
      default: begin
        rs_state_nxt = RS_SYNC;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  logic [SW_W-1:0] sw_sync [SYNC_STAGES];
  logic [SW_W-1:0] sw_s;
  logic [DB_W-1:0] db_cnt  [SW_W];
  logic [SW_W-1:0] sw_out_q;
  logic [SW_W-1:0] sw_chg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sw_sync[k] <= '0;
      end
    end else begin
      sw_sync[0] <= io.sw_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sw_sync[k] <= sw_sync[k-1];
      end
    end
  end

  assign sw_s = sw_sync[SYNC_STAGES-1];

  // Debounce keeps running under rst_core so switch state is valid at release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_out_q <= '0;
      sw_chg_q <= '0;
      for (int i = 0; i < SW_W; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SW_W; i++) begin
        sw_chg_q[i] <= 1'b0;
        if (sw_s[i] == sw_out_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          sw_out_q[i] <= sw_s[i];
          sw_chg_q[i] <= 1'b1;
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   rx_s;
  logic [RF_W-1:0]        rf_cnt;
  logic                   rx_out_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync <= '1;
    end else begin
      rx_sync <= {rx_sync[SYNC_STAGES-2:0], io.rx_in};
    end
  end

  assign rx_s = rx_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_cnt   <= '0;
      rx_out_q <= 1'b1;
    end else if (rx_s == rx_out_q) begin
      rf_cnt <= '0;
    end else if (rf_cnt == RF_LAST) begin
      rx_out_q <= rx_s;
      rf_cnt   <= '0;
    end else begin
      rf_cnt <= rf_cnt + RF_W'(1);
    end
  end

  generate
    if (TX_REG != 0) begin : g_tx_reg
      logic tx_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          tx_q <= 1'b1;
        end else begin
          tx_q <= rst_core_q ? 1'b1 : io.tx_in;
        end
      end
      assign io.tx_out = tx_q;
    end else begin : g_tx_comb
      // rst_core_q is set asynchronously, so the line idles high with no clock.
      assign io.tx_out = rst_core_q | io.tx_in;
    end
  endgenerate

  logic [LED_W-1:0] led_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q <= '0;
    end else begin
      led_q <= rst_core_q ? '0 : io.led_in;
    end
  end

  assign io.rst_core = rst_core_q;
  assign io.io_ready = io_ready_q;
  assign io.sw_out   = sw_out_q;
  assign io.sw_chg   = sw_chg_q;
  assign io.rx_out   = rx_out_q;
  assign io.led_out  = led_q;

endmodule

// File: tb/tb_uart_io_conditioner.sv
// Bench for uart_io_conditioner: directed scenarios plus random pin activity,
// checked each cycle against a sample-window reference model via a scoreboard.
module tb_uart_io_conditioner;

  localparam int SW_W  = 8;
  localparam int LED_W = 16;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int RXF   = 3;
  localparam int HOLD  = 8;

  typedef struct packed {
    logic             rst_core;
    logic             io_ready;
    logic [SW_W-1:0]  sw_out;
    logic [SW_W-1:0]  sw_chg;
    logic             rx_out;
    logic             tx_out;
    logic [LED_W-1:0] led_out;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  uart_io_conditioner_if #(.SW_W(SW_W), .LED_W(LED_W)) io ();

  uart_io_conditioner #(
    .SW_W(SW_W), .LED_W(LED_W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYC(DEB),
    .RX_FILT(RXF), .RST_HOLD(HOLD), .TX_REG(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.rst_core = 1'b1;
    e.io_ready = 1'b0;
    e.sw_out   = '0;
    e.sw_chg   = '0;
    e.rx_out   = 1'b1;
    e.tx_out   = 1'b1;
    e.led_out  = '0;
    return e;
  endfunction

  // Reference model: an output bit changes when the last N synchronised samples
  // (pin values SYNC edges old) all disagree with it.
  exp_t            exp_q[$];
  logic [SW_W-1:0] sw_pin_h[$];
  logic            rx_pin_h[$];
  logic [SW_W-1:0] s_h[$];
  logic            rs_h[$];
  logic [SW_W-1:0] m_sw = '0;
  logic            m_rx = 1'b1;
  int              n = 0;

  always @(posedge clk) begin : model
    exp_t            e;
    logic            held;
    logic [SW_W-1:0] s;
    logic [SW_W-1:0] chg;
    logic            rs;
    logic            all_diff;
    if (!rst) begin
      n = 0;
      sw_pin_h.delete();
      rx_pin_h.delete();
      s_h.delete();
      rs_h.delete();
      m_sw = '0;
      m_rx = 1'b1;
      e = reset_exp();
    end else begin
      held = (n < SYNC + HOLD);
      n++;
      sw_pin_h.push_back(io.sw_in);
      rx_pin_h.push_back(io.rx_in);
      s  = (n > SYNC) ? sw_pin_h[n-1-SYNC] : '0;
      rs = (n > SYNC) ? rx_pin_h[n-1-SYNC] : 1'b1;
      s_h.push_back(s);
      rs_h.push_back(rs);
      chg = '0;
      if (s_h.size() >= DEB) begin
        for (int i = 0; i < SW_W; i++) begin
          all_diff = 1'b1;
          for (int j = 1; j <= DEB; j++)
            if (s_h[s_h.size()-j][i] == m_sw[i]) all_diff = 1'b0;
          chg[i] = all_diff;
        end
      end
      m_sw = m_sw ^ chg;
      if (rs_h.size() >= RXF) begin
        all_diff = 1'b1;
        for (int j = 1; j <= RXF; j++)
          if (rs_h[rs_h.size()-j] == m_rx) all_diff = 1'b0;
        if (all_diff) m_rx = ~m_rx;
      end
      e.rst_core = (n < SYNC + HOLD);
      e.io_ready = ~e.rst_core;
      e.sw_out   = m_sw;
      e.sw_chg   = chg;
      e.rx_out   = m_rx;
      e.tx_out   = held ? 1'b1 : io.tx_in;
      e.led_out  = held ? '0 : io.led_in;
    end
    exp_q.push_back(e);
  end

  exp_t mon_e;
  always @(negedge clk) begin : monitor
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (!rst) mon_e = reset_exp();
      chk("sb_rst_core", 32'(io.rst_core), 32'(mon_e.rst_core));
      chk("sb_io_ready", 32'(io.io_ready), 32'(mon_e.io_ready));
      chk("sb_sw_out",   32'(io.sw_out),   32'(mon_e.sw_out));
      chk("sb_sw_chg",   32'(io.sw_chg),   32'(mon_e.sw_chg));
      chk("sb_rx_out",   32'(io.rx_out),   32'(mon_e.rx_out));
      chk("sb_tx_out",   32'(io.tx_out),   32'(mon_e.tx_out));
      chk("sb_led_out",  32'(io.led_out),  32'(mon_e.led_out));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int   lat;
    int   fall_e;
    int   rise_e;
    logic tx_pat [4];
    logic [SW_W-1:0] bnc [8];
    tx_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    bnc    = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00};

    io.sw_in  = '0;
    io.rx_in  = 1'b1;
    io.tx_in  = 1'b0;
    io.led_in = 16'hFFFF;

    // 1: reset and release
    repeat (5) @(negedge clk);
    chk("rst_rst_core", 32'(io.rst_core), 32'd1);
    chk("rst_io_ready", 32'(io.io_ready), 32'd0);
    chk("rst_rx_out",   32'(io.rx_out),   32'd1);
    chk("rst_tx_out",   32'(io.tx_out),   32'd1);
    chk("rst_led_out",  32'(io.led_out),  32'd0);
    #1 rst = 1'b1;
    lat = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (io.rst_core == 1'b0) begin
        lat = e;
        break;
      end
      chk("hold_tx_out",  32'(io.tx_out),  32'd1);
      chk("hold_led_out", 32'(io.led_out), 32'd0);
    end
    chk("release_edge", 32'(lat), 32'(SYNC + HOLD));
    chk("release_io_ready", 32'(io.io_ready), 32'd1);

    // 2: clean press
    @(negedge clk) io.sw_in = 8'h05;
    lat = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (io.sw_out == 8'h05) begin
        lat = e;
        break;
      end
    end
    chk("press_latency", 32'(lat), 32'd6);
    chk("press_chg", 32'(io.sw_chg), 32'h05);
    @(posedge clk); #1;
    chk("press_chg_clear", 32'(io.sw_chg), 32'h00);

    // 3: bounce rejection
    @(negedge clk) io.sw_in = 8'h00;
    repeat (10) @(negedge clk);
    chk("bounce_start", 32'(io.sw_out), 32'h00);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk) io.sw_in = (i < 8) ? bnc[i] : 8'h00;
      @(posedge clk); #1;
      chk("bounce_sw_out0", 32'(io.sw_out[0]), 32'd0);
      chk("bounce_sw_chg",  32'(io.sw_chg),    32'd0);
    end

    // 4: RX glitch filter
    @(negedge clk) io.rx_in = 1'b0;
    @(negedge clk);
    @(negedge clk) io.rx_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("rx_glitch", 32'(io.rx_out), 32'd1);
    end
    @(negedge clk) io.rx_in = 1'b0;
    fall_e = 0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      if (fall_e == 0 && io.rx_out == 1'b0) fall_e = e;
    end
    @(negedge clk) io.rx_in = 1'b1;
    rise_e = 0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      if (rise_e == 0 && io.rx_out == 1'b1) rise_e = e;
    end
    chk("rx_fall_latency", 32'(fall_e), 32'd5);
    chk("rx_rise_latency", 32'(rise_e), 32'd5);

    // 5: TX / LED pass-through
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) io.tx_in = tx_pat[i];
      @(posedge clk); #1;
      chk("tx_pattern", 32'(io.tx_out), 32'(tx_pat[i]));
    end
    @(negedge clk) io.led_in = 16'hA5A5;
    @(posedge clk); #1;
    chk("led_pass", 32'(io.led_out), 32'hA5A5);

    // 6: reset in the middle of a debounce
    @(negedge clk) io.sw_in = 8'hFF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_sw_out",   32'(io.sw_out),   32'h00);
    chk("midrst_sw_chg",   32'(io.sw_chg),   32'h00);
    chk("midrst_rx_out",   32'(io.rx_out),   32'd1);
    chk("midrst_rst_core", 32'(io.rst_core), 32'd1);
    chk("midrst_io_ready", 32'(io.io_ready), 32'd0);
    chk("midrst_tx_out",   32'(io.tx_out),   32'd1);
    chk("midrst_led_out",  32'(io.led_out),  32'd0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    lat = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (io.sw_out == 8'hFF) begin
        lat = e;
        break;
      end
    end
    chk("midrst_relatch_latency", 32'(lat), 32'd6);
    chk("midrst_relatch_chg", 32'(io.sw_chg), 32'hFF);
    @(posedge clk); #1;
    chk("midrst_relatch_chg_clear", 32'(io.sw_chg), 32'h00);
    repeat (8) @(negedge clk);

    // random pin activity with one reset in the middle
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) io.sw_in = SW_W'($urandom);
      if ($urandom_range(0, 3) == 0) io.rx_in = ~io.rx_in;
      io.tx_in  = 1'($urandom);
      io.led_in = LED_W'($urandom);
      if (c == 200) #1 rst = 1'b0;
      if (c == 204) #1 rst = 1'b1;
    end
    repeat (3) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
